ifu_axi_rd_bridge: RTL and testbench
====================================

Name: ifu_axi_rd_bridge

Overview:
- Sits directly downstream of the instruction-fetch unit's simple request port and upstream of the AXI4 interconnect.
- Converts each single-word fetch request (valid/addr held until ready) into one AXI4 read transaction: AR handshake, then a single R beat.
- Returns the instruction word to the fetch unit with a one-cycle ready pulse.
- Adds an alignment check, a response check and an R-channel timeout with drain, so a faulty slave cannot hang or desynchronise fetch.

Parameters:
- ADDR_W, 32, fetch/AXI address width
- DATA_W, 32, instruction and AXI data width
- ID_W, 4, AXI ID width
- AR_ID, 0, constant ARID driven on every request
- TIMEOUT_CYCLES, 1024, maximum cycles in R_WAIT before a forced error completion; 0 disables the timeout

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ifu_r_valid_i  in  1  fetch request; held high until ifu_r_ready_o
- ifu_r_addr_i  in  ADDR_W  fetch PC
- ifu_r_ready_o  out  1  one-cycle completion pulse
- ifu_r_data_o  out  DATA_W  instruction; valid while ifu_r_ready_o=1
- ifu_r_err_o  out  1  fetch fault; qualified by ifu_r_ready_o
- axi_araddr_o  out  ADDR_W
- axi_arvalid_o  out  1
- axi_arready_i  in  1
- axi_arid_o  out  ID_W
- axi_arlen_o  out  8
- axi_arsize_o  out  3
- axi_arburst_o  out  2
- axi_rvalid_i  in  1
- axi_rready_o  out  1
- axi_rdata_i  in  DATA_W
- axi_rresp_i  in  2
- axi_rlast_i  in  1
- axi_rid_i  in  ID_W  ignored; single outstanding transaction

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE; arvalid=0, rready=0, ifu_r_ready_o=0, ifu_r_err_o=0; ifu_r_data_o=0, araddr=0; timeout counter=0.
- Reset mid-transaction: all of the above are restored on the next edge and no response is awaited. The interconnect shares rst.
- Constant AR fields: arlen=0, arsize=2 (4 B), arburst=INCR, arid=AR_ID.
- FSM transitions:
  - IDLE: valid & addr[1:0]==0 -> latch addr -> AR. Valid & misaligned -> RESP with err=1, data=NOP (0x00000013), no AXI traffic.
  - AR: arvalid=1 with a stable araddr. On arvalid&arready -> R_WAIT. arvalid is never withdrawn before arready, and AR has no timeout.
  - R_WAIT: rready=1; the counter increments each cycle. On rvalid -> latch rdata -> RESP, with err = (rresp!=OKAY) | !rlast. If the counter reaches TIMEOUT_CYCLES-1 with no rvalid -> RESP with err=1, data=NOP, and set drain_pending.
  - RESP: ifu_r_ready_o=1 for exactly one cycle with registered data and err. Next state is DRAIN if drain_pending, else IDLE. The request seen during RESP is the one being completed and is never re-accepted.
  - DRAIN: rready=1; discard beats until rvalid&rlast -> IDLE, clearing drain_pending. New fetch requests stall here.
- Counter: cleared on entry to R_WAIT and is only active there. Its width is clog2(TIMEOUT_CYCLES)+1.
- Latency: with arready=1 and rvalid the cycle after the AR handshake, ifu_r_ready_o asserts 3 cycles after valid is first seen in IDLE. For a misaligned address it asserts 1 cycle after.
- Outputs: all registered. No combinational path from any AXI input to any fetch-side output.
- Capacity: at most one outstanding transaction; no request buffering.

Decomposition:
- Shared package:
  - AXI constants: RESP_OKAY/EXOKAY/SLVERR/DECERR, BURST_INCR, SIZE_4B
  - NOP encoding 0x00000013
  - state enum {IDLE, AR, R_WAIT, RESP, DRAIN}
- One natural sub-module, ifu_axi_rd_tmo_cnt: clear/enable/expire counter parameterised by TIMEOUT_CYCLES. The rest stays flat.

Test Plan:
- Request addr 0x80000000; arready=1 immediately; rvalid next cycle with rdata=0x00100093, rresp=0, rlast=1 -> ready pulse 3 cycles after the request, data 0x00100093, err=0, exactly one AR.
- arready held low 5 cycles -> arvalid stays 1 and araddr stays stable throughout; completion occurs after the handshake.
- rresp=SLVERR (2), rdata=0xDEADBEEF -> ready with err=1, data=0xDEADBEEF. Also rlast=0 with rresp=OKAY -> err=1.
- Addr 0x80000002 -> ready 1 cycle later, err=1, data 0x00000013, arvalid never asserted.
- TIMEOUT_CYCLES=8, no rvalid -> err completion with data 0x00000013 after 8 R_WAIT cycles. The next request is blocked until the late beat (rlast=1) is drained, then that request completes normally.
- rst asserted in R_WAIT -> next edge arvalid=0, rready=0, ready=0, state IDLE. A following request at 0x80000004 completes normally.

Source files
------------

// File: rtl/ifu_axi_rd_bridge_pkg.sv
// Shared constants for the fetch-to-AXI read bridge: AXI encodings, the NOP
// returned on faults, and the bridge FSM state encoding.
package ifu_axi_rd_bridge_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_AR     = 3'd1;
    localparam state_t ST_R_WAIT = 3'd2;
    localparam state_t ST_RESP   = 3'd3;
    localparam state_t ST_DRAIN  = 3'd4;

endpackage

// File: rtl/ifu_axi_rd_tmo_cnt.sv
// R-channel watchdog: counts enabled cycles since the last clear and flags
// the cycle in which TIMEOUT_CYCLES-1 is reached. TIMEOUT_CYCLES=0 never expires.
module ifu_axi_rd_tmo_cnt #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = (TIMEOUT_CYCLES != 0) && en &&
                    (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ifu_axi_rd_bridge.sv
// Converts single-word fetch requests into single-beat AXI4 reads, with
// alignment/response checks and an R-channel timeout that drains the late beat.
module ifu_axi_rd_bridge
    import ifu_axi_rd_bridge_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int ID_W           = 4,
    parameter int AR_ID          = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_r_valid_i,
    input  logic [ADDR_W-1:0] ifu_r_addr_i,
    output logic              ifu_r_ready_o,
    output logic [DATA_W-1:0] ifu_r_data_o,
    output logic              ifu_r_err_o,
    output logic [ADDR_W-1:0] axi_araddr_o,
    output logic              axi_arvalid_o,
    input  logic              axi_arready_i,
    output logic [ID_W-1:0]   axi_arid_o,
    output logic [7:0]        axi_arlen_o,
    output logic [2:0]        axi_arsize_o,
    output logic [1:0]        axi_arburst_o,
    input  logic              axi_rvalid_i,
    output logic              axi_rready_o,
    input  logic [DATA_W-1:0] axi_rdata_i,
    input  logic [1:0]        axi_rresp_i,
    input  logic              axi_rlast_i,
    input  logic [ID_W-1:0]   axi_rid_i
);

    state_t state;
    logic   drain_pending;
    logic   tmo_clr;
    logic   tmo_en;
    logic   tmo_expire;

    // Only one read is ever outstanding, so the returned ID carries no information.
    logic unused_rid;
    assign unused_rid = ^axi_rid_i;

    assign axi_arid_o    = ID_W'(AR_ID);
    assign axi_arlen_o   = 8'd0;
    assign axi_arsize_o  = SIZE_4B;
    assign axi_arburst_o = BURST_INCR;

    assign tmo_clr = (state == ST_AR) && axi_arready_i;
    assign tmo_en  = (state == ST_R_WAIT);

    ifu_axi_rd_tmo_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_tmo_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmo_clr),
        .en     (tmo_en),
        .expire (tmo_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            drain_pending <= 1'b0;
            axi_araddr_o  <= '0;
            axi_arvalid_o <= 1'b0;
            axi_rready_o  <= 1'b0;
            ifu_r_ready_o <= 1'b0;
            ifu_r_err_o   <= 1'b0;
            ifu_r_data_o  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ifu_r_valid_i) begin
                        if (ifu_r_addr_i[1:0] == 2'b00) begin
                            axi_araddr_o  <= ifu_r_addr_i;
                            axi_arvalid_o <= 1'b1;
                            state         <= ST_AR;
                        end else begin
                            ifu_r_data_o  <= DATA_W'(NOP_INSN);
                            ifu_r_err_o   <= 1'b1;
                            ifu_r_ready_o <= 1'b1;
                            state         <= ST_RESP;
                        end
                    end
                end
                ST_AR: begin
                    if (axi_arready_i) begin
                        axi_arvalid_o <= 1'b0;
                        axi_rready_o  <= 1'b1;
                        state         <= ST_R_WAIT;
                    end
                end
                ST_R_WAIT: begin
                    // A beat arriving in the expiry cycle still wins over the timeout.
                    if (axi_rvalid_i) begin
                        ifu_r_data_o  <= axi_rdata_i;
                        ifu_r_err_o   <= (axi_rresp_i != RESP_OKAY) | ~axi_rlast_i;
                        ifu_r_ready_o <= 1'b1;
                        axi_rready_o  <= 1'b0;
                        state         <= ST_RESP;
                    end else if (tmo_expire) begin
                        ifu_r_data_o  <= DATA_W'(NOP_INSN);
                        ifu_r_err_o   <= 1'b1;
                        ifu_r_ready_o <= 1'b1;
                        axi_rready_o  <= 1'b0;
                        drain_pending <= 1'b1;
                        state         <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    ifu_r_ready_o <= 1'b0;
                    if (drain_pending) begin
                        axi_rready_o <= 1'b1;
                        state        <= ST_DRAIN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (axi_rvalid_i && axi_rlast_i) begin
                        axi_rready_o  <= 1'b0;
                        drain_pending <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_axi_rd_bridge.sv
// Directed bench for ifu_axi_rd_bridge: a vector table of single fetches plus
// hand-written timeout/drain and mid-transaction reset sequences.
module tb_ifu_axi_rd_bridge;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_r_valid_i;
    logic [31:0] ifu_r_addr_i;
    logic        ifu_r_ready_o;
    logic [31:0] ifu_r_data_o;
    logic        ifu_r_err_o;
    logic [31:0] axi_araddr_o;
    logic        axi_arvalid_o;
    logic        axi_arready_i;
    logic [3:0]  axi_arid_o;
    logic [7:0]  axi_arlen_o;
    logic [2:0]  axi_arsize_o;
    logic [1:0]  axi_arburst_o;
    logic        axi_rvalid_i;
    logic        axi_rready_o;
    logic [31:0] axi_rdata_i;
    logic [1:0]  axi_rresp_i;
    logic        axi_rlast_i;
    logic [3:0]  axi_rid_i;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ifu_axi_rd_bridge #(
        .ADDR_W(32), .DATA_W(32), .ID_W(4), .AR_ID(0), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_r_valid_i (ifu_r_valid_i),
        .ifu_r_addr_i  (ifu_r_addr_i),
        .ifu_r_ready_o (ifu_r_ready_o),
        .ifu_r_data_o  (ifu_r_data_o),
        .ifu_r_err_o   (ifu_r_err_o),
        .axi_araddr_o  (axi_araddr_o),
        .axi_arvalid_o (axi_arvalid_o),
        .axi_arready_i (axi_arready_i),
        .axi_arid_o    (axi_arid_o),
        .axi_arlen_o   (axi_arlen_o),
        .axi_arsize_o  (axi_arsize_o),
        .axi_arburst_o (axi_arburst_o),
        .axi_rvalid_i  (axi_rvalid_i),
        .axi_rready_o  (axi_rready_o),
        .axi_rdata_i   (axi_rdata_i),
        .axi_rresp_i   (axi_rresp_i),
        .axi_rlast_i   (axi_rlast_i),
        .axi_rid_i     (axi_rid_i)
    );

    typedef struct {
        logic [31:0] addr;
        int          ar_dly;
        int          r_dly;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        rlast;
        int          exp_lat;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_ars;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one fetch from a negedge and plays a simple AXI slave until the
    // completion pulse or a 200-cycle bound. Latency counts negedges after the request.
    task automatic run_fetch(input logic [31:0] addr, input int ad, input int rd,
                             input logic [31:0] rdat, input logic [1:0] rrsp,
                             input logic rlst, input bit give_r,
                             output int lat, output logic [31:0] dat, output logic er,
                             output int ars, output bit addr_stable);
        int  arw = 0;
        int  rw  = 0;
        bit  armed = 0, hs = 0, rhs = 0, done = 0;
        lat = -1; dat = '0; er = 1'b0; ars = 0; addr_stable = 1'b1;
        ifu_r_valid_i = 1'b1;
        ifu_r_addr_i  = addr;
        for (int c = 1; c <= 200 && !done; c++) begin
            @(negedge clk);
            if (hs) begin ars++; armed = 1; rw = 0; hs = 0; end
            if (rhs) begin axi_rvalid_i = 1'b0; rhs = 0; armed = 0; end
            if (ifu_r_ready_o) begin
                lat = c; dat = ifu_r_data_o; er = ifu_r_err_o; done = 1;
                ifu_r_valid_i = 1'b0;
            end
            if (axi_arvalid_o) begin
                if (axi_araddr_o !== addr) addr_stable = 1'b0;
                axi_arready_i = (arw >= ad);
                arw++;
                if (axi_arready_i) hs = 1;
            end else begin
                axi_arready_i = 1'b0;
            end
            if (armed && give_r && !axi_rvalid_i) begin
                if (rw >= rd) begin
                    axi_rvalid_i = 1'b1; axi_rdata_i = rdat;
                    axi_rresp_i = rrsp; axi_rlast_i = rlst;
                end
                rw++;
            end
            if (axi_rvalid_i && axi_rready_o) rhs = 1;
        end
        axi_arready_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t        vecs[9];
    int          lat, ars, stall;
    logic [31:0] dat;
    logic        er;
    bit          stable;

    initial begin
        vecs[0] = '{32'h8000_0000, 0, 0, 32'h0010_0093, 2'd0, 1'b1, 3,  32'h0010_0093, 1'b0, 1};
        vecs[1] = '{32'h8000_0100, 5, 0, 32'h0000_0297, 2'd0, 1'b1, 8,  32'h0000_0297, 1'b0, 1};
        vecs[2] = '{32'h8000_0200, 0, 0, 32'hDEAD_BEEF, 2'd2, 1'b1, 3,  32'hDEAD_BEEF, 1'b1, 1};
        vecs[3] = '{32'h8000_0204, 0, 0, 32'h1234_5678, 2'd0, 1'b0, 3,  32'h1234_5678, 1'b1, 1};
        vecs[4] = '{32'h8000_0002, 0, 0, 32'h0,         2'd0, 1'b1, 1,  NOP,           1'b1, 0};
        vecs[5] = '{32'h8000_0208, 1, 3, 32'h00a0_0513, 2'd3, 1'b1, 7,  32'h00a0_0513, 1'b1, 1};
        vecs[6] = '{32'h8000_0001, 0, 0, 32'h0,         2'd0, 1'b1, 1,  NOP,           1'b1, 0};
        vecs[7] = '{32'h8000_020C, 2, 1, 32'h0000_0001, 2'd1, 1'b1, 6,  32'h0000_0001, 1'b1, 1};
        // Beat lands in the very cycle the counter hits TIMEOUT_CYCLES-1.
        vecs[8] = '{32'h8000_0210, 0, 7, 32'hCAFE_F00D, 2'd0, 1'b1, 10, 32'hCAFE_F00D, 1'b0, 1};

        rst = 1'b1; ifu_r_valid_i = 1'b0; ifu_r_addr_i = '0;
        axi_arready_i = 1'b0; axi_rvalid_i = 1'b0; axi_rdata_i = '0;
        axi_rresp_i = '0; axi_rlast_i = 1'b0; axi_rid_i = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_arvalid", axi_arvalid_o, 0);
        chk("rst_rready",  axi_rready_o, 0);
        chk("rst_ready",   ifu_r_ready_o, 0);
        chk("rst_err",     ifu_r_err_o, 0);
        chk("rst_data",    ifu_r_data_o, 0);
        chk("rst_araddr",  axi_araddr_o, 0);
        chk("arlen",       axi_arlen_o, 0);
        chk("arsize",      axi_arsize_o, 2);
        chk("arburst",     axi_arburst_o, 1);
        chk("arid",        axi_arid_o, 0);

        for (int i = 0; i < 9; i++) begin
            run_fetch(vecs[i].addr, vecs[i].ar_dly, vecs[i].r_dly, vecs[i].rdata,
                      vecs[i].rresp, vecs[i].rlast, 1'b1, lat, dat, er, ars, stable);
            chk($sformatf("v%0d_lat", i),    lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_data", i),   dat, vecs[i].exp_data);
            chk($sformatf("v%0d_err", i),    er,  vecs[i].exp_err);
            chk($sformatf("v%0d_ars", i),    ars, vecs[i].exp_ars);
            chk($sformatf("v%0d_araddr", i), stable, 1);
            @(negedge clk);
        end

        // Timeout: 8 R_WAIT cycles after the handshake at edge 2.
        run_fetch(32'h8000_0300, 0, 0, 32'h0, 2'd0, 1'b1, 1'b0, lat, dat, er, ars, stable);
        chk("tmo_lat",  lat, 10);
        chk("tmo_data", dat, NOP);
        chk("tmo_err",  er, 1);
        chk("tmo_ars",  ars, 1);
        @(negedge clk);
        chk("drain_rready", axi_rready_o, 1);
        ifu_r_valid_i = 1'b1; ifu_r_addr_i = 32'h8000_0320;
        stall = 0;
        repeat (5) begin
            @(negedge clk);
            if (axi_arvalid_o || ifu_r_ready_o) stall++;
        end
        chk("drain_stall", stall, 0);
        axi_rvalid_i = 1'b1; axi_rlast_i = 1'b1; axi_rdata_i = 32'hBAD0_BAD0; axi_rresp_i = 2'd0;
        @(negedge clk);
        axi_rvalid_i = 1'b0;
        chk("drain_done_rready", axi_rready_o, 0);
        run_fetch(32'h8000_0320, 0, 0, 32'h0020_0113, 2'd0, 1'b1, 1'b1, lat, dat, er, ars, stable);
        chk("post_drain_lat",  lat, 3);
        chk("post_drain_data", dat, 32'h0020_0113);
        chk("post_drain_err",  er, 0);
        @(negedge clk);

        // Reset while waiting on R.
        ifu_r_valid_i = 1'b1; ifu_r_addr_i = 32'h8000_0400; axi_arready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rwait_rready", axi_rready_o, 1);
        rst = 1'b1; ifu_r_valid_i = 1'b0; axi_arready_i = 1'b0;
        @(negedge clk);
        chk("mid_rst_arvalid", axi_arvalid_o, 0);
        chk("mid_rst_rready",  axi_rready_o, 0);
        chk("mid_rst_ready",   ifu_r_ready_o, 0);
        rst = 1'b0;
        @(negedge clk);
        run_fetch(32'h8000_0004, 0, 0, 32'h0000_0073, 2'd0, 1'b1, 1'b1, lat, dat, er, ars, stable);
        chk("post_rst_lat",  lat, 3);
        chk("post_rst_data", dat, 32'h0000_0073);
        chk("post_rst_err",  er, 0);
        chk("post_rst_ars",  ars, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
